// File: rtl/alu_seq.sv
// alu_seq: one-command-at-a-time sequencer for an external combinational ALU.
// It registers operands/opcode, captures the ALU result one cycle later,
// flags divide-by-zero, and holds the result until the consumer accepts it.
module alu_seq #(
  parameter logic [7:0] ACC_INIT = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_op,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  input  logic       cmd_acc,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [3:0] alu_sel,
  input  logic [7:0] alu_out,
  input  logic       alu_carry,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_data,
  output logic       res_carry,
  output logic       res_zero,
  output logic       res_err,
  output logic [7:0] res_count
);

  localparam logic [3:0] OP_DIV = 4'b0011;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_t;

  state_t     state;
  logic [7:0] acc;
  logic       div_zero;

  // Divide-by-zero is judged on the registered operands seen by the ALU.
  always_comb begin
    div_zero = (alu_sel == OP_DIV) && (alu_b == '0);
  end

  // Sequencer FSM with registered handshake and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= ACC_INIT;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= '0;
      res_data  <= '0;
      res_carry <= 1'b0;
      res_zero  <= 1'b0;
      res_err   <= 1'b0;
      res_count <= '0;
      res_valid <= 1'b0;
      cmd_ready <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            alu_a     <= cmd_acc ? acc : cmd_a;
            alu_b     <= cmd_b;
            alu_sel   <= cmd_op;
            cmd_ready <= 1'b0;
            state     <= EXEC;
          end
        end
        EXEC: begin
          if (div_zero) begin
            // ALU output is meaningless here; accumulator keeps its value.
            res_data  <= 8'hFF;
            res_carry <= 1'b0;
            res_zero  <= 1'b0;
            res_err   <= 1'b1;
          end else begin
            res_data  <= alu_out;
            res_carry <= alu_carry;
            res_zero  <= (alu_out == '0);
            res_err   <= 1'b0;
            acc       <= alu_out;
          end
          res_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            cmd_ready <= 1'b1;
            res_count <= res_count + 8'd1;
            state     <= IDLE;
          end
        end
        default: begin
          res_valid <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed, table-driven bench for alu_seq with a small
// combinational ALU stand-in driven from the sequencer's registered outputs.
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_op;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic       cmd_acc;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [3:0] alu_sel;
  logic [7:0] alu_out;
  logic       alu_carry;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic       res_carry;
  logic       res_zero;
  logic       res_err;
  logic [7:0] res_count;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_count;

  alu_seq #(.ACC_INIT(8'h33)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_acc   (cmd_acc),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_out   (alu_out),
    .alu_carry (alu_carry),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_carry (res_carry),
    .res_zero  (res_zero),
    .res_err   (res_err),
    .res_count (res_count)
  );

  always #5 clk = ~clk;

  // ALU stand-in: 0 add, 1 sub (carry = borrow), 2 and, 3 div, 4 or, 5 xor.
  // Divide by zero returns a junk value with carry set so capture must ignore it.
  always_comb begin
    logic [8:0] sum;
    sum       = {1'b0, alu_a} + {1'b0, alu_b};
    alu_out   = alu_a;
    alu_carry = 1'b0;
    case (alu_sel)
      4'h0: begin alu_out = sum[7:0]; alu_carry = sum[8]; end
      4'h1: begin alu_out = alu_a - alu_b; alu_carry = (alu_a < alu_b); end
      4'h2: alu_out = alu_a & alu_b;
      4'h3: begin
        if (alu_b == 8'h00) begin alu_out = 8'h5A; alu_carry = 1'b1; end
        else alu_out = alu_a / alu_b;
      end
      4'h4: alu_out = alu_a | alu_b;
      4'h5: alu_out = alu_a ^ alu_b;
      default: alu_out = alu_a;
    endcase
  end

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       use_acc;
    logic [7:0] exp_a;
    logic [7:0] exp_data;
    logic       exp_carry;
    logic       exp_zero;
    logic       exp_err;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full transaction with checks; caller is at posedge+1 with the DUT idle.
  task automatic run_vec(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("v%0d", idx);
    chk({tag, "_cmd_ready"}, {7'd0, cmd_ready}, 8'd1);
    cmd_valid = 1'b1;
    cmd_op    = v.op;
    cmd_a     = v.a;
    cmd_b     = v.b;
    cmd_acc   = v.use_acc;
    res_ready = 1'b0;
    tick();                          // accept edge N
    cmd_valid = 1'b0;
    chk({tag, "_alu_a"}, alu_a, v.exp_a);
    chk({tag, "_alu_b"}, alu_b, v.b);
    chk({tag, "_alu_sel"}, {4'd0, alu_sel}, {4'd0, v.op});
    chk({tag, "_valid_early"}, {7'd0, res_valid}, 8'd0);
    tick();
    tick();                          // after N+2, consumer still stalled
    chk({tag, "_res_valid"}, {7'd0, res_valid}, 8'd1);
    chk({tag, "_res_data"}, res_data, v.exp_data);
    chk({tag, "_res_carry"}, {7'd0, res_carry}, {7'd0, v.exp_carry});
    chk({tag, "_res_zero"}, {7'd0, res_zero}, {7'd0, v.exp_zero});
    chk({tag, "_res_err"}, {7'd0, res_err}, {7'd0, v.exp_err});
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    exp_count = exp_count + 8'd1;
    chk({tag, "_ready_back"}, {7'd0, cmd_ready}, 8'd1);
    chk({tag, "_valid_drop"}, {7'd0, res_valid}, 8'd0);
    chk({tag, "_count"}, res_count, exp_count);
  endtask

  // Unchecked transaction used for bulk counting.
  task automatic quick_cmd();
    cmd_valid = 1'b1;
    cmd_op    = 4'h0;
    cmd_a     = 8'h01;
    cmd_b     = 8'h01;
    cmd_acc   = 1'b0;
    res_ready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    res_ready = 1'b0;
    exp_count = exp_count + 8'd1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_count = '0;
    tick();
  endtask

  initial begin
    vecs[0]  = '{4'h4, 8'h00, 8'h00, 1'b1, 8'h33, 8'h33, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{4'h0, 8'hF0, 8'h20, 1'b0, 8'hF0, 8'h10, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{4'h1, 8'h55, 8'h10, 1'b1, 8'h10, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{4'h3, 8'h08, 8'h00, 1'b0, 8'h08, 8'hFF, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{4'h0, 8'h77, 8'h05, 1'b1, 8'h00, 8'h05, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{4'h3, 8'h64, 8'h07, 1'b0, 8'h64, 8'h0E, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{4'h2, 8'h00, 8'h0C, 1'b1, 8'h0E, 8'h0C, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{4'h5, 8'hAA, 8'hAA, 1'b0, 8'hAA, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{4'h0, 8'hFF, 8'h01, 1'b0, 8'hFF, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{4'h3, 8'h00, 8'h00, 1'b1, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{4'h1, 8'h03, 8'h05, 1'b0, 8'h03, 8'hFE, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{4'h4, 8'h12, 8'h21, 1'b1, 8'hFE, 8'hFF, 1'b0, 1'b0, 1'b0};

    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = '0;
    cmd_a = '0;
    cmd_b = '0;
    cmd_acc = 1'b0;
    res_ready = 1'b0;
    exp_count = '0;

    // Reset state while rst is held.
    #2;
    chk("rst_cmd_ready", {7'd0, cmd_ready}, 8'd1);
    chk("rst_res_valid", {7'd0, res_valid}, 8'd0);
    chk("rst_alu_a", alu_a, 8'h00);
    chk("rst_res_data", res_data, 8'h00);
    chk("rst_res_count", res_count, 8'h00);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

    // Backpressure: stall in DONE with a competing command on the input.
    cmd_valid = 1'b1; cmd_op = 4'h0; cmd_a = 8'h01; cmd_b = 8'h02; cmd_acc = 1'b0;
    tick();
    cmd_op = 4'h5; cmd_a = 8'hC3; cmd_b = 8'h3C;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_res_valid", {7'd0, res_valid}, 8'd1);
      chk("bp_cmd_ready", {7'd0, cmd_ready}, 8'd0);
      chk("bp_res_data", res_data, 8'h03);
      chk("bp_alu_a", alu_a, 8'h01);
      chk("bp_alu_sel", {4'd0, alu_sel}, 8'h00);
      tick();
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    exp_count = exp_count + 8'd1;
    chk("bp_release_ready", {7'd0, cmd_ready}, 8'd1);
    chk("bp_release_valid", {7'd0, res_valid}, 8'd0);
    chk("bp_count", res_count, exp_count);

    // Reset while EXEC: in-flight result is dropped.
    cmd_valid = 1'b1; cmd_op = 4'h0; cmd_a = 8'h10; cmd_b = 8'h10; cmd_acc = 1'b0;
    tick();
    cmd_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rexec_cmd_ready", {7'd0, cmd_ready}, 8'd1);
    chk("rexec_res_valid", {7'd0, res_valid}, 8'd0);
    chk("rexec_res_count", res_count, 8'h00);
    chk("rexec_alu_a", alu_a, 8'h00);
    chk("rexec_alu_b", alu_b, 8'h00);
    chk("rexec_res_data", res_data, 8'h00);
    chk("rexec_res_carry", {7'd0, res_carry}, 8'd0);
    chk("rexec_res_zero", {7'd0, res_zero}, 8'd0);
    tick();
    chk("rexec_hold_ready", {7'd0, cmd_ready}, 8'd1);
    chk("rexec_hold_valid", {7'd0, res_valid}, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_count = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rexec_post_valid", {7'd0, res_valid}, 8'd0);
      chk("rexec_post_ready", {7'd0, cmd_ready}, 8'd1);
      chk("rexec_post_count", res_count, 8'h00);
    end
    // Accumulator back at ACC_INIT.
    run_vec(vecs[0], 100);

    // Reset while DONE also drops the result.
    cmd_valid = 1'b1; cmd_op = 4'h0; cmd_a = 8'h01; cmd_b = 8'h01; cmd_acc = 1'b0;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("rdone_pre_valid", {7'd0, res_valid}, 8'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rdone_res_valid", {7'd0, res_valid}, 8'd0);
    chk("rdone_res_count", res_count, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    exp_count = '0;
    tick();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("rdone_no_count", res_count, 8'h00);

    // Counter wrap after 256 completions from reset.
    do_reset();
    for (int i = 0; i < 255; i++) quick_cmd();
    chk("wrap_255", res_count, 8'hFF);
    quick_cmd();
    chk("wrap_256", res_count, 8'h00);
    chk("wrap_model", exp_count, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter: ACC_INIT, default 8'h00, reset/initial value of the internal accumulator.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: cmd_valid  input  1  command present.
REQ-005 SHALL have port: cmd_ready  output  1  sequencer can accept a command.
REQ-006 SHALL have port: cmd_op  input  4  ALU opcode (same 16-op encoding as the team ALU alu_sel).
REQ-007 SHALL have port: cmd_a  input  8  operand A.
REQ-008 SHALL have port: cmd_b  input  8  operand B.
REQ-009 SHALL have port: cmd_acc  input  1  1 = use accumulator instead of cmd_a as operand A.
REQ-010 SHALL have port: alu_a  output  8  registered operand A to ALU.
REQ-011 SHALL have port: alu_b  output  8  registered operand B to ALU.
REQ-012 SHALL have port: alu_sel  output  4  registered opcode to ALU.
REQ-013 SHALL have port: alu_out  input  8  ALU result.
REQ-014 SHALL have port: alu_carry  input  1  ALU carry-out.
REQ-015 SHALL have port: res_valid  output  1  result present.
REQ-016 SHALL have port: res_ready  input  1  consumer accepts result.
REQ-017 SHALL have port: res_data  output  8  captured result.
REQ-018 SHALL have port: res_carry  output  1  captured carry.
REQ-019 SHALL have port: res_zero  output  1  1 when res_data == 8'h00.
REQ-020 SHALL have port: res_err  output  1  divide-by-zero flag.
REQ-021 SHALL have port: res_count  output  8  count of completed results, wraps 8'hFF -> 8'h00.

Function
REQ-022 SHALL implement FSM states IDLE, EXEC, DONE; reset state IDLE.
REQ-023 SHALL drive cmd_ready = 1 only in IDLE; res_valid = 1 only in DONE.
REQ-024 IDLE: on cmd_valid && cmd_ready, SHALL register alu_a (= acc if cmd_acc else cmd_a), alu_b = cmd_b, alu_sel = cmd_op; go to EXEC.
REQ-025 EXEC: SHALL capture alu_out/alu_carry into res_data/res_carry, compute res_zero from captured data, go to DONE (exactly one cycle).
REQ-026 Latency: command accepted at edge N SHALL give res_valid = 1 after edge N+2; max throughput one command per 3 cycles.
REQ-027 Divide-by-zero (alu_sel == 4'b0011 and alu_b == 0) in EXEC SHALL capture res_data = 8'hFF, res_carry = 0, res_err = 1 and ignore alu_out; otherwise res_err = 0.
REQ-028 On a non-error capture, accumulator SHALL load res_data; on error it SHALL hold.
REQ-029 DONE: res_data/res_carry/res_zero/res_err SHALL stay stable while res_ready = 0; on res_ready = 1 go to IDLE and increment res_count (mod 256).
REQ-030 cmd_valid in EXEC/DONE SHALL be ignored (no accept, no state change); alu_a/alu_b/alu_sel SHALL hold from accept until the next accept.
REQ-031 All arithmetic width/carry semantics SHALL be those of the ALU; the sequencer SHALL not modify alu_out except per REQ-027.

Reset
REQ-032 rst asserted, at any state, SHALL immediately force IDLE, accumulator = ACC_INIT, and alu_a, alu_b, alu_sel, res_data, res_carry, res_zero, res_err, res_count = 0, res_valid = 0, cmd_ready = 1 (held while rst = 1).
REQ-033 Reset during EXEC or DONE SHALL discard the in-flight result; no res_valid and no res_count increment SHALL follow for it.

Verification
REQ-034 Add: op 0000, a=8'hF0, b=8'h20, accepted at edge N -> res_valid after N+2, res_data=8'h10, res_carry=1, res_zero=0, acc=8'h10.
REQ-035 Chain: acc=8'h10, cmd_acc=1, op 0001, cmd_a=8'h55, b=8'h10 -> alu_a=8'h10, res_data=8'h00, res_zero=1.
REQ-036 Div-by-zero: op 0011, a=8'h08, b=8'h00 -> res_data=8'hFF, res_err=1, res_carry=0, acc unchanged.
REQ-037 Backpressure: res_ready=0 for 5 cycles in DONE with cmd_valid=1 -> outputs stable, cmd_ready=0, no accept; res_ready=1 -> IDLE, res_count+1.
REQ-038 Reset mid-EXEC -> res_valid stays 0, cmd_ready=1 while rst high and after release, acc=ACC_INIT, res_count=0.
REQ-039 256 completed results from reset -> res_count returns to 8'h00.
